// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage with BOOT / RUN / HALT control.
//
// Keeps the program counter, drives it to a combinational instruction ROM and
// captures the returned word into a single if_* output register that the
// decode stage consumes with a valid/ready handshake. Taken branches/jumps
// (redirect) flush the output register and reload the PC. A halt request
// parks the unit without fetching until a redirect restarts it.
//
// Ports
//   i_clock            clock, all state updates on the rising edge
//   i_reset            asynchronous reset, active low
//   o_rom_addr         byte address to the instruction ROM (= current PC)
//   i_rom_data         instruction word for o_rom_addr, same cycle
//   i_redirect_valid   branch/jump taken this cycle
//   i_redirect_pc      branch/jump target byte address
//   i_halt_req         request to stop fetching
//   i_id_ready         decode stage accepts o_if_* this cycle
//   o_if_valid         o_if_inst / o_if_pc hold a valid fetched instruction
//   o_if_inst          fetched instruction
//   o_if_pc            byte address of o_if_inst
//   o_if_pc_plus4      o_if_pc + 4 (mod 2**32)
//   o_halted           FSM is in HALT
//   o_align_fault      sticky: a misaligned redirect target was seen
//   o_fetch_count      instructions fetched since reset (wraps)
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          ADDR_WIDTH = 8
) (
   input  logic        i_clock,
   input  logic        i_reset,
   output logic [31:0] o_rom_addr,
   input  logic [31:0] i_rom_data,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_halt_req,
   input  logic        i_id_ready,
   output logic        o_if_valid,
   output logic [31:0] o_if_inst,
   output logic [31:0] o_if_pc,
   output logic [31:0] o_if_pc_plus4,
   output logic        o_halted,
   output logic        o_align_fault,
   output logic [31:0] o_fetch_count
);

   // The ROM size only matters to the ROM itself (the PC runs across the
   // whole 32-bit space); reject nonsensical widths at elaboration.
   if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_addr_width
      $error("fetch_unit: ADDR_WIDTH must be in 1..30");
   end

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic [31:0] r_pc;
   logic        r_if_valid;
   logic [31:0] r_if_inst;
   logic [31:0] r_if_pc;
   logic        r_align_fault;
   logic [31:0] r_fetch_count;

   logic        w_redirect;
   logic        w_fire;
   logic        w_drain;

   // ------------------------------------------------------------------------
   // Control decode
   // ------------------------------------------------------------------------
   // Redirects are dropped in BOOT; elsewhere they win over everything.
   assign w_redirect = i_redirect_valid && (r_state != S_BOOT);

   // A halt request suppresses the fetch in the cycle it is taken, so it is
   // folded into the fire condition alongside the redirect.
   assign w_fire = (r_state == S_RUN) && (!r_if_valid || i_id_ready) &&
                   !i_redirect_valid && !i_halt_req;

   // Decode consumed the held entry and nothing replaces it.
   assign w_drain = r_if_valid && i_id_ready && !w_fire;

   // ------------------------------------------------------------------------
   // FSM: state register + next-state logic
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= S_BOOT;
      end else begin
         // NOTE: sequential state always uses non-blocking assignment so every
         // register samples pre-edge values regardless of statement order.
         r_state <= w_next_state;
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns the output; no latch.
      w_next_state = r_state;
      unique case (r_state)
         S_BOOT:  w_next_state = S_RUN;
         S_RUN: begin
            if (w_redirect) begin
               w_next_state = S_RUN;
            end else if (i_halt_req) begin
               w_next_state = S_HALT;
            end
         end
         S_HALT: begin
            if (w_redirect) begin
               w_next_state = S_RUN;
            end
         end
         default: w_next_state = S_BOOT;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: PC, output register, fault flag, fetch counter
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_pc          <= RESET_PC;
         r_if_valid    <= 1'b0;
         r_if_inst     <= 32'h0;
         r_if_pc       <= 32'h0;
         r_align_fault <= 1'b0;
         r_fetch_count <= 32'h0;
      end else if (w_redirect) begin
         // Flush regardless of i_id_ready; the low address bits are dropped.
         r_pc       <= {i_redirect_pc[31:2], 2'b00};
         r_if_valid <= 1'b0;
         if (i_redirect_pc[1:0] != 2'b00) begin
            r_align_fault <= 1'b1;
         end
      end else if (w_fire) begin
         r_if_inst     <= i_rom_data;
         r_if_pc       <= r_pc;
         r_if_valid    <= 1'b1;
         r_pc          <= r_pc + 32'd4;
         r_fetch_count <= r_fetch_count + 32'd1;
      end else if (w_drain) begin
         r_if_valid <= 1'b0;
      end
      // Otherwise (stall, BOOT, idle HALT) everything holds.
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign o_rom_addr    = r_pc;
   assign o_if_valid    = r_if_valid;
   assign o_if_inst     = r_if_inst;
   assign o_if_pc       = r_if_pc;
   assign o_if_pc_plus4 = r_if_pc + 32'd4;
   assign o_halted      = (r_state == S_HALT);
   assign o_align_fault = r_align_fault;
   assign o_fetch_count = r_fetch_count;

endmodule
